// File: rtl/svpwm_gate_driver.sv
`default_nettype none
// ============================================================================
//  Module      : svpwm_gate_driver
//  Description : Center-aligned carrier, double-buffered compare/period
//                registers, and per-phase dead-time generators producing six
//                complementary gate drives plus zero/peak ADC strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module svpwm_gate_driver #(
    parameter int PWM_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [3*PWM_WIDTH-1:0] pwm_in_tdata,
    input  logic                   pwm_in_tvalid,
    input  logic [PWM_WIDTH-1:0]   period,
    input  logic [DT_WIDTH-1:0]    deadtime,
    input  logic                   enable,
    output logic [2:0]             gate_h,
    output logic [2:0]             gate_l,
    output logic                   cnt_zero,
    output logic                   cnt_peak,
    output logic [PWM_WIDTH-1:0]   cnt
);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                      dir;
    logic [2:0][PWM_WIDTH-1:0] shadow_cmp;
    logic [2:0][PWM_WIDTH-1:0] active_cmp;
    logic                      pending;
    logic [PWM_WIDTH-1:0]      active_period;
    logic [PWM_WIDTH-1:0]      eff_period;
    logic [PWM_WIDTH-1:0]      cnt_inc;
    logic [PWM_WIDTH-1:0]      cnt_dec;
    logic                      load;

    // A load edge is any enabled cycle sitting at carrier zero. The period
    // being loaded already governs the counting step taken on that edge, so a
    // freshly loaded zero period parks the carrier immediately.
    assign load       = enable && (cnt == '0);
    assign eff_period = load ? period : active_period;
    assign cnt_inc    = cnt + 1'b1;
    assign cnt_dec    = cnt - 1'b1;

    assign cnt_zero = enable && (cnt == '0);
    assign cnt_peak = enable && (cnt == active_period) && (active_period != '0);

    // Up/down carrier: 0,1..P,P-1..1 with the direction flag as the only state
    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (eff_period == '0) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (dir == DIR_UP) begin
            cnt <= cnt_inc;
            if (cnt_inc == eff_period) begin
                dir <= DIR_DOWN;
            end
        end else begin
            cnt <= cnt_dec;
            if (cnt_dec == '0) begin
                dir <= DIR_UP;
            end
        end
    end

    // Shadow capture and zero-aligned transfer; a beat landing in the load
    // cycle is written after the transfer reads the old shadow, so it stays
    // pending for the following zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_cmp    <= '0;
            active_cmp    <= '0;
            active_period <= '0;
            pending       <= 1'b0;
        end else begin
            if (load) begin
                active_period <= period;
                if (pending) begin
                    active_cmp <= shadow_cmp;
                    pending    <= 1'b0;
                end
            end
            if (pwm_in_tvalid) begin
                shadow_cmp <= pwm_in_tdata;
                pending    <= 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_phase
            logic                phase_raw;
            logic                prev_raw;
            logic                armed;
            logic                drv_h;
            logic                drv_l;
            logic [DT_WIDTH-1:0] dead_cnt;

            // Registered compare of this phase against the carrier
            always_ff @(posedge clk) begin
                if (!rstn || !enable) begin
                    phase_raw <= 1'b0;
                end else begin
                    phase_raw <= (active_cmp[i] > cnt);
                end
            end

            // Dead-band: any change of the requested side (or the first cycle
            // after start-up) blanks both gates for deadtime cycles; a change
            // inside the band restarts it. Outputs are only ever complementary
            // or both low.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    drv_h    <= 1'b0;
                    drv_l    <= 1'b0;
                    prev_raw <= 1'b0;
                    armed    <= 1'b0;
                    dead_cnt <= '0;
                end else if (!enable) begin
                    drv_h    <= 1'b0;
                    drv_l    <= 1'b0;
                    prev_raw <= 1'b0;
                    armed    <= 1'b0;
                    dead_cnt <= deadtime;
                end else if (!armed || (phase_raw != prev_raw)) begin
                    armed    <= 1'b1;
                    prev_raw <= phase_raw;
                    if (deadtime == '0) begin
                        drv_h    <= phase_raw;
                        drv_l    <= ~phase_raw;
                        dead_cnt <= '0;
                    end else begin
                        drv_h    <= 1'b0;
                        drv_l    <= 1'b0;
                        dead_cnt <= deadtime - 1'b1;
                    end
                end else if (dead_cnt != '0) begin
                    drv_h    <= 1'b0;
                    drv_l    <= 1'b0;
                    dead_cnt <= dead_cnt - 1'b1;
                end else begin
                    drv_h <= phase_raw;
                    drv_l <= ~phase_raw;
                end
            end

            assign gate_h[i] = drv_h;
            assign gate_l[i] = drv_l;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_svpwm_gate_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_svpwm_gate_driver
//  Description : Self-checking bench; carrier position/history model plus
//                directed scenarios with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svpwm_gate_driver;

    logic        clk;
    logic        rstn;
    logic [47:0] tdata;
    logic        tvalid;
    logic [15:0] period;
    logic [7:0]  deadtime;
    logic        enable;
    logic [2:0]  gate_h;
    logic [2:0]  gate_l;
    logic        cnt_zero;
    logic        cnt_peak;
    logic [15:0] cnt;

    int n_checks = 0;
    int n_fails  = 0;

    svpwm_gate_driver #(.PWM_WIDTH(16), .DT_WIDTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pwm_in_tdata (tdata),
        .pwm_in_tvalid(tvalid),
        .period       (period),
        .deadtime     (deadtime),
        .enable       (enable),
        .gate_h       (gate_h),
        .gate_l       (gate_l),
        .cnt_zero     (cnt_zero),
        .cnt_peak     (cnt_peak),
        .cnt          (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Carrier value from position inside the current 2P-cycle period
    function automatic int cnt_of(input int pos, input int p);
        return (pos <= p) ? pos : (2 * p - pos);
    endfunction

    // ---------------- behavioural model ----------------
    int          m_pos = 0;
    int          m_p = 0;
    logic [2:0][15:0] m_acmp = '0;
    logic [2:0][15:0] m_shadow = '0;
    bit          m_pend = 0;
    logic [2:0]  m_r = '0;
    int          m_stab [3] = '{0, 0, 0};
    int          m_en_run = 0;
    logic [2:0]  m_gh = '0;
    logic [2:0]  m_gl = '0;
    bit          m_valid = 0;

    initial begin : model
        int         oc;
        int         dd;
        logic [2:0] nr;
        forever begin
            @(posedge clk);
            oc = cnt_of(m_pos, m_p);
            dd = int'(deadtime);
            nr = 3'b000;
            if (!rstn) begin
                m_pos = 0; m_p = 0; m_acmp = '0; m_shadow = '0; m_pend = 0;
                m_gh = '0; m_gl = '0; m_en_run = 0;
            end else begin
                if (enable) begin
                    m_en_run++;
                    for (int x = 0; x < 3; x++) begin
                        // a side is driven only once raw has held for D+1 samples
                        if (m_en_run > dd && m_stab[x] > dd) begin
                            m_gh[x] = m_r[x];
                            m_gl[x] = ~m_r[x];
                        end else begin
                            m_gh[x] = 1'b0;
                            m_gl[x] = 1'b0;
                        end
                        nr[x] = (int'(m_acmp[x]) > oc);
                    end
                    if (oc == 0) begin
                        m_p = int'(period);
                        if (m_pend) begin
                            m_acmp = m_shadow;
                            m_pend = 0;
                        end
                        m_pos = (m_p == 0) ? 0 : 1;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_en_run = 0; m_gh = '0; m_gl = '0; m_pos = 0;
                end
                if (tvalid) begin
                    m_shadow = tdata;
                    m_pend   = 1;
                end
            end
            for (int x = 0; x < 3; x++) begin
                if (nr[x] == m_r[x]) m_stab[x] = (m_stab[x] < 1000000) ? m_stab[x] + 1 : m_stab[x];
                else m_stab[x] = 1;
            end
            m_r = nr;
            m_valid = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        int ec;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                ec = cnt_of(m_pos, m_p);
                check("cnt", cnt, ec);
                check("cnt_zero", cnt_zero, enable && (ec == 0));
                check("cnt_peak", cnt_peak, enable && (ec == m_p) && (m_p != 0));
                check("gate_h", gate_h, m_gh);
                check("gate_l", gate_l, m_gl);
                check("gate_overlap", gate_h & gate_l, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int u, input int v, input int w);
        tdata  = {u[15:0], v[15:0], w[15:0]};
        tvalid = 1'b1;
        cyc(1);
        tvalid = 1'b0;
    endtask

    task automatic wait_zero(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            if (cnt == 16'd0) break;
            cyc(1);
        end
        check({tag, "_zero_timeout"}, (k < 200), 1);
    endtask

    task automatic measure(input int len, output int hu, output int lv, output int hw,
                           output int bl, output int zc, output int pk);
        hu = 0; lv = 0; hw = 0; bl = 0; zc = 0; pk = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hu += int'(gate_h[2]);
            lv += int'(gate_l[1]);
            hw += int'(gate_h[0]);
            bl += int'(!gate_h[2] && !gate_l[2]);
            zc += int'(cnt_zero);
            if (cnt_peak && pk < 0) pk = i;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int hu, lv, hw, bl, zc, pk, w1, w2, w3, z1, z2, mx, k, first_l;
        rstn = 1'b0; enable = 1'b0; tvalid = 1'b0; tdata = '0; period = '0; deadtime = '0;
        cyc(3);
        check("reset_gates", {gate_h, gate_l}, 0);
        check("reset_cnt", cnt, 0);

        // Disabled with random beats: everything stays quiet
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tvalid   = 1'($urandom_range(0, 1));
            tdata    = {16'($urandom), 16'($urandom), 16'($urandom)};
            period   = 16'($urandom_range(0, 20));
            deadtime = 8'($urandom_range(0, 5));
            cyc(1);
        end
        tvalid = 1'b0;
        check("disabled_gates", {gate_h, gate_l}, 0);
        check("disabled_strobes", {cnt_zero, cnt_peak}, 0);

        // Basic modulation, no dead-time
        rstn = 1'b0; cyc(1); rstn = 1'b1;
        period = 16'd10; deadtime = 8'd0;
        beat(5, 0, 11);
        enable = 1'b1;
        cyc(1);
        wait_zero("t1");
        measure(20, hu, lv, hw, bl, zc, pk);
        check("t1_u_high", hu, 9);
        check("t1_v_low_const", lv, 20);
        check("t1_w_high_const", hw, 20);
        check("t1_zero_count", zc, 1);
        check("t1_peak_offset", pk, 10);
        check("t1_next_zero", cnt, 0);

        // Last beat wins; beat in the load cycle waits for the next zero
        cyc(3);
        beat(3, 3, 3);
        cyc(2);
        beat(7, 7, 7);
        cyc(1);
        wait_zero("t3");
        tdata = {16'd9, 16'd9, 16'd9};
        tvalid = 1'b1;
        w1 = 0; w2 = 0; w3 = 0;
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            if (i >= 3 && i < 23) w1 += int'(gate_h[2]);
            else if (i >= 23 && i < 43) w2 += int'(gate_h[2]);
            else if (i >= 43) w3 += int'(gate_h[2]);
            if (i == 0) begin
                @(posedge clk);
                #1;
                tvalid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("t3_load_applies_7", w1, 13);
        check("t3_loadcycle_beat_9", w2, 17);
        check("t3_steady_9", w3, 17);

        // Period change mid-period
        cyc(1);
        wait_zero("t4");
        z1 = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) period = 16'd4;
            cyc(1);
            if (cnt == 16'd0) begin z1 = i; break; end
        end
        check("t4_old_period_len", z1, 20);
        z2 = -1; mx = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1);
            if (int'(cnt) > mx) mx = int'(cnt);
            if (cnt == 16'd0) begin z2 = i; break; end
        end
        check("t4_new_period_len", z2, 8);
        check("t4_new_peak", mx, 4);

        // Dead-time 3 with cmp_u=5
        enable = 1'b0; cyc(2);
        deadtime = 8'd3; period = 16'd10;
        beat(5, 0, 11);
        enable = 1'b1;
        cyc(1);
        wait_zero("t2");
        measure(20, hu, lv, hw, bl, zc, pk);
        check("t2_u_high", hu, 6);
        check("t2_u_both_low", bl, 6);
        check("t2_v_low_const", lv, 20);

        // Narrow pulse: toggle inside the band restarts it, high side never on
        beat(1, 0, 11);
        cyc(1);
        wait_zero("t2b_a");
        cyc(1);
        wait_zero("t2b_b");
        measure(20, hu, lv, hw, bl, zc, pk);
        check("t2b_u_high", hu, 0);
        check("t2b_u_both_low", bl, 4);

        // Reset while U high side is on
        beat(5, 0, 11);
        cyc(1);
        wait_zero("t5");
        for (k = 0; k < 100; k++) begin
            if (gate_h[2]) break;
            cyc(1);
        end
        check("t5_u_high_seen", (k < 100), 1);
        rstn = 1'b0;
        cyc(1);
        check("t5_reset_gates", {gate_h, gate_l}, 0);
        check("t5_reset_cnt", cnt, 0);
        rstn = 1'b1;
        first_l = -1; hu = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (gate_l[2] && first_l < 0) first_l = j;
            hu += int'(gate_h[2]);
            if (j == 3) check("t5_cnt_restart", cnt, 3);
        end
        @(posedge clk);
        #1;
        check("t5_low_side_delay", first_l, 4);
        check("t5_no_high", hu, 0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
